// File: rtl/gpio_pattern_sequencer.sv
// gpio_pattern_sequencer
// Plays a small table of {hold, status, pattern} entries onto the user IO
// checkbit field and status nibble. Each entry stays visible for hold+1
// cycles. The sequence can loop or stop, and it can be aborted at any time.
// When a sequence finishes normally, the last entry stays on the pads.
// An abort returns the pads to the idle code with the output drivers released.

module gpio_pattern_sequencer #(
  parameter int          DEPTH     = 8,
  parameter logic [15:0] IDLE_PAT  = 16'h0000,
  parameter logic [3:0]  IDLE_STAT = 4'h0,
  localparam int         AW        = $clog2(DEPTH)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [31:0]   cfg_wdata,
  input  logic [AW:0]   num_entries,
  input  logic          loop_en,
  input  logic          start,
  input  logic          abort,
  output logic [15:0]   pat_out,
  output logic [3:0]    stat_out,
  output logic [19:0]   io_oeb,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] entry_idx
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t        state;
  logic [31:0]   pat_table [DEPTH];
  logic [11:0]   hold_cnt;
  logic [AW:0]   len_q;
  logic          loop_q;

  logic [AW:0]   eff_len;
  logic          at_last;
  logic [AW-1:0] next_idx;
  logic [31:0]   next_word;
  logic [31:0]   first_word;

  // Table write port; out-of-range indices are dropped, and there is no reset on the table
  always_ff @(posedge wb_clk_i) begin
    if (cfg_we && ({1'b0, cfg_addr} < DEPTH_W)) begin
      pat_table[cfg_addr] <= cfg_wdata;
    end
  end

  // Clamp the requested length to the table size and work out which entry to load next
  always_comb begin
    eff_len    = (num_entries > DEPTH_W) ? DEPTH_W : num_entries;
    at_last    = (({1'b0, entry_idx} + 1'b1) == len_q);
    next_idx   = at_last ? '0 : (entry_idx + 1'b1);
    next_word  = pat_table[next_idx];
    first_word = pat_table[0];
  end

  // Sequencer FSM with all outputs registered; abort takes priority over everything else
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      pat_out   <= IDLE_PAT;
      stat_out  <= IDLE_STAT;
      io_oeb    <= '1;
      busy      <= 1'b0;
      done      <= 1'b0;
      entry_idx <= '0;
      hold_cnt  <= '0;
      len_q     <= '0;
      loop_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        pat_out  <= IDLE_PAT;
        stat_out <= IDLE_STAT;
        io_oeb   <= '1;
        busy     <= 1'b0;
        hold_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (eff_len == '0) begin
                done <= 1'b1;
              end else begin
                state     <= HOLD;
                busy      <= 1'b1;
                io_oeb    <= '0;
                len_q     <= eff_len;
                loop_q    <= loop_en;
                entry_idx <= '0;
                pat_out   <= first_word[15:0];
                stat_out  <= first_word[19:16];
                hold_cnt  <= first_word[31:20];
              end
            end
          end
          HOLD: begin
            if (hold_cnt != '0) begin
              hold_cnt <= hold_cnt - 1'b1;
            end else if (!at_last || loop_q) begin
              entry_idx <= next_idx;
              pat_out   <= next_word[15:0];
              stat_out  <= next_word[19:16];
              hold_cnt  <= next_word[31:20];
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpio_pattern_sequencer.sv
// Testbench for gpio_pattern_sequencer.
// Two instances share one stimulus stream: DEPTH=8 and DEPTH=6.
// The DEPTH=6 instance keeps the same 3-bit address width.
// Both are compared every cycle against an entry/time based reference model.

module tb_gpio_pattern_sequencer;

  logic clock = 1'b0;
  logic wb_rst_i;
  logic cfg_we;
  logic [2:0] cfg_addr;
  logic [31:0] cfg_wdata;
  logic [3:0] num_entries;
  logic loop_en;
  logic start;
  logic abort;

  logic [15:0] pat_o [2];
  logic [3:0] stat_o [2];
  logic [19:0] oeb_o [2];
  logic busy_o [2];
  logic done_o [2];
  logic [2:0] idx_o [2];

  int check_cnt = 0;
  int pass_cnt = 0;

  int depth_of [2] = '{8, 6};
  logic [31:0] m_tab [2][8];
  bit m_run [2];
  bit m_loop [2];
  bit m_drv [2];
  bit m_done [2];
  int m_idx [2];
  int m_left [2];
  int m_len [2];
  logic [15:0] m_pat [2];
  logic [3:0] m_stat [2];

  always #5 clock = ~clock;

  gpio_pattern_sequencer #(.DEPTH(8)) dut8 (
    .wb_clk_i(clock), .wb_rst_i(wb_rst_i), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .num_entries(num_entries), .loop_en(loop_en),
    .start(start), .abort(abort), .pat_out(pat_o[0]), .stat_out(stat_o[0]),
    .io_oeb(oeb_o[0]), .busy(busy_o[0]), .done(done_o[0]), .entry_idx(idx_o[0])
  );

  gpio_pattern_sequencer #(.DEPTH(6)) dut6 (
    .wb_clk_i(clock), .wb_rst_i(wb_rst_i), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .num_entries(num_entries), .loop_en(loop_en),
    .start(start), .abort(abort), .pat_out(pat_o[1]), .stat_out(stat_o[1]),
    .io_oeb(oeb_o[1]), .busy(busy_o[1]), .done(done_o[1]), .entry_idx(idx_o[1])
  );

  // Single comparison point: counts the check and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  function automatic void modelReset(int k);
    m_run[k] = 0; m_loop[k] = 0; m_drv[k] = 0; m_done[k] = 0;
    m_idx[k] = 0; m_left[k] = 0; m_len[k] = 0;
    m_pat[k] = 16'h0000; m_stat[k] = 4'h0;
  endfunction

  function automatic void modelShow(int k, int i);
    m_idx[k] = i;
    m_pat[k] = m_tab[k][i][15:0];
    m_stat[k] = m_tab[k][i][19:16];
    m_left[k] = int'(m_tab[k][i][31:20]) + 1;
  endfunction

  // One clock edge of the reference: an entry is shown for hold+1 cycles, then the next one
  function automatic void modelStep(int k);
    m_done[k] = 0;
    if (abort) begin
      m_run[k] = 0; m_drv[k] = 0;
      m_pat[k] = 16'h0000; m_stat[k] = 4'h0;
    end else if (!m_run[k]) begin
      if (start) begin
        int n;
        n = (int'(num_entries) < depth_of[k]) ? int'(num_entries) : depth_of[k];
        if (n == 0) begin
          m_done[k] = 1;
        end else begin
          m_run[k] = 1; m_drv[k] = 1; m_len[k] = n; m_loop[k] = loop_en;
          modelShow(k, 0);
        end
      end
    end else begin
      m_left[k]--;
      if (m_left[k] == 0) begin
        if (m_idx[k] < m_len[k] - 1) modelShow(k, m_idx[k] + 1);
        else if (m_loop[k]) modelShow(k, 0);
        else begin
          m_run[k] = 0; m_done[k] = 1;
        end
      end
    end
    if (cfg_we && int'(cfg_addr) < depth_of[k]) m_tab[k][cfg_addr] = cfg_wdata;
  endfunction

  task automatic checkAll();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("pat%0d", k), 32'(pat_o[k]), 32'(m_pat[k]));
      checkOutput($sformatf("stat%0d", k), 32'(stat_o[k]), 32'(m_stat[k]));
      checkOutput($sformatf("oeb%0d", k), 32'(oeb_o[k]), m_drv[k] ? 32'h0 : 32'hFFFFF);
      checkOutput($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(m_run[k]));
      checkOutput($sformatf("done%0d", k), 32'(done_o[k]), 32'(m_done[k]));
      checkOutput($sformatf("idx%0d", k), 32'(idx_o[k]), 32'(m_idx[k]));
    end
  endtask

  task automatic checkReset(input string tag);
    for (int k = 0; k < 2; k++) begin
      checkOutput({tag, "_pat"}, 32'(pat_o[k]), 32'h0000);
      checkOutput({tag, "_stat"}, 32'(stat_o[k]), 32'h0);
      checkOutput({tag, "_oeb"}, 32'(oeb_o[k]), 32'hFFFFF);
      checkOutput({tag, "_busy"}, 32'(busy_o[k]), 32'h0);
      checkOutput({tag, "_done"}, 32'(done_o[k]), 32'h0);
      checkOutput({tag, "_idx"}, 32'(idx_o[k]), 32'h0);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then compare just after it
  task automatic applyStimulus(input logic we, input logic [2:0] addr, input logic [31:0] wd,
                               input logic [3:0] n, input logic lp, input logic st, input logic ab);
    cfg_we = we; cfg_addr = addr; cfg_wdata = wd;
    num_entries = n; loop_en = lp; start = st; abort = ab;
    @(posedge clock);
    for (int k = 0; k < 2; k++) modelStep(k);
    #1;
    checkAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic writeEntry(input logic [2:0] addr, input logic [11:0] hold,
                            input logic [3:0] st, input logic [15:0] pat);
    applyStimulus(1'b1, addr, {hold, st, pat}, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Bound the whole run so a stuck design still reaches a verdict
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int max_idx [2];
    int cycles;

    wb_rst_i = 1'b1;
    cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; num_entries = 0;
    loop_en = 0; start = 0; abort = 0;
    for (int k = 0; k < 2; k++) modelReset(k);
    #1;
    checkReset("rst");
    @(posedge clock);
    #1 wb_rst_i = 1'b0;

    $display("[TB] preload table");
    for (int a = 0; a < 8; a++)
      writeEntry(3'(a), 12'($urandom_range(0, 3)), 4'($urandom), 16'($urandom));
    writeEntry(3'd0, 12'd2, 4'hA, 16'hAB40);
    writeEntry(3'd1, 12'd0, 4'h5, 16'h1968);
    writeEntry(3'd2, 12'd3, 4'h5, 16'hAB51);

    $display("[TB] single pass");
    applyStimulus(1'b0, 3'd0, 32'h0, 4'd3, 1'b0, 1'b1, 1'b0);
    checkOutput("sp_first", 32'(pat_o[0]), 32'hAB40);
    idleCycles(3);
    checkOutput("sp_second", 32'(pat_o[0]), 32'h1968);
    idleCycles(1);
    checkOutput("sp_third", 32'(pat_o[0]), 32'hAB51);
    idleCycles(4);
    checkOutput("sp_done", 32'(done_o[0]), 32'h1);
    checkOutput("sp_hold_pat", 32'(pat_o[0]), 32'hAB51);
    checkOutput("sp_hold_oeb", 32'(oeb_o[0]), 32'h0);
    idleCycles(2);

    $display("[TB] loop and abort");
    applyStimulus(1'b0, 3'd0, 32'h0, 4'd3, 1'b1, 1'b1, 1'b0);
    idleCycles(8);
    checkOutput("loop_wrap_pat", 32'(pat_o[0]), 32'hAB40);
    checkOutput("loop_wrap_busy", 32'(busy_o[0]), 32'h1);
    applyStimulus(1'b0, 3'd0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("abort_pat", 32'(pat_o[0]), 32'h0000);
    checkOutput("abort_oeb", 32'(oeb_o[0]), 32'hFFFFF);
    idleCycles(2);

    $display("[TB] zero length start");
    applyStimulus(1'b0, 3'd0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("n0_done", 32'(done_o[0]), 32'h1);
    checkOutput("n0_busy", 32'(busy_o[0]), 32'h0);
    idleCycles(1);

    $display("[TB] oversize length");
    applyStimulus(1'b0, 3'd0, 32'h0, 4'd15, 1'b0, 1'b1, 1'b0);
    max_idx = '{0, 0};
    cycles = 0;
    while ((busy_o[0] || busy_o[1]) && cycles < 200) begin
      for (int k = 0; k < 2; k++) if (int'(idx_o[k]) > max_idx[k]) max_idx[k] = int'(idx_o[k]);
      idleCycles(1);
      cycles++;
    end
    checkOutput("n15_finished", 32'(busy_o[0]), 32'h0);
    checkOutput("n15_max8", 32'(max_idx[0]), 32'd7);
    checkOutput("n15_max6", 32'(max_idx[1]), 32'd5);
    idleCycles(2);

    $display("[TB] start with abort");
    applyStimulus(1'b0, 3'd0, 32'h0, 4'd3, 1'b0, 1'b1, 1'b1);
    checkOutput("sa_busy", 32'(busy_o[0]), 32'h0);
    idleCycles(1);

    $display("[TB] live write");
    applyStimulus(1'b0, 3'd0, 32'h0, 4'd3, 1'b0, 1'b1, 1'b0);
    writeEntry(3'd1, 12'd0, 4'h5, 16'h1DCD);
    writeEntry(3'd6, 12'd1, 4'h3, 16'hDEAD);
    idleCycles(1);
    checkOutput("live_pat", 32'(pat_o[0]), 32'h1DCD);

    $display("[TB] async reset mid-sequence");
    #2 wb_rst_i = 1'b1;
    #1;
    checkReset("arst");
    for (int k = 0; k < 2; k++) modelReset(k);
    @(posedge clock);
    #1;
    checkReset("arst_hold");
    wb_rst_i = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'h0, 4'd3, 1'b0, 1'b1, 1'b0);
    checkOutput("arst_restart", 32'(pat_o[0]), 32'hAB40);
    idleCycles(10);

    $display("[TB] random phase");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                    {12'($urandom_range(0, 4)), 20'($urandom)},
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
